// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the single-port RAM request controller.
//   RAM_ADDR_W / RAM_DATA_W : default RAM geometry (16 x 8-bit)
//   REQ_A / REQ_B           : requester ids carried in the response tag
//   tag_t                   : in-flight tag {rd, id} riding the RAM latency
package ram_ctrl_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic rd;   // slot carries a read that must be answered
        logic id;   // requester that issued it
    } tag_t;

    localparam tag_t TAG_IDLE = '{rd: 1'b0, id: REQ_A};

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request lines (bit 0 = A, bit 1 = B)
//   gnt[1:0]   : one-hot grant, combinational, never without matching req
// A tie goes to the requester favoured by the pointer; the pointer then
// flips to favour the other one. Any grant counts as an accept since the
// grant is the ready of a valid/ready handshake.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio_q, prio_d;   // 0: A wins a tie, 1: B wins a tie

    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (gnt[0])      prio_d = 1'b1;
        else if (gnt[1]) prio_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Two-requester front end for an external single-port synchronous-read RAM.
//   clk, reset_n                 : clock, async active-low reset
//   a_* / b_*                    : request (valid/ready/write/addr/wdata) and
//                                  read response (rvalid pulse + rdata)
//   ram_address/data_in/write_en : registered RAM port drive
//   ram_data_out                 : RAM read data (registered inside the RAM)
// Accepted request at edge E drives the RAM from flops; the RAM acts at E+1;
// the read data is steered back at E+2 using a tag that follows the request.
module ram_sp_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_en,
    input  logic [DATA_W-1:0] ram_data_out
);

    logic [1:0] gnt;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (reset_n),
        .req   ({b_valid, a_valid}),
        .gnt   (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];

    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
    logic              ram_write_en_q, ram_write_en_d;
    tag_t              tag1_q, tag1_d, tag2_q, tag2_d;
    logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        sel_write      = gnt[1] ? b_write : a_write;
        sel_addr       = gnt[1] ? b_addr  : a_addr;
        sel_wdata      = gnt[1] ? b_wdata : a_wdata;

        ram_address_d  = ram_address_q;
        ram_data_in_d  = ram_data_in_q;
        ram_write_en_d = 1'b0;
        tag1_d         = TAG_IDLE;
        if (|gnt) begin
            ram_address_d  = sel_addr;
            ram_data_in_d  = sel_wdata;
            ram_write_en_d = sel_write;
            tag1_d         = '{rd: ~sel_write, id: gnt[1]};
        end

        // Stage 1 is the RAM's own access cycle; the tag just moves along.
        tag2_d     = tag1_q;

        a_rvalid_d = tag2_q.rd && (tag2_q.id == REQ_A);
        b_rvalid_d = tag2_q.rd && (tag2_q.id == REQ_B);
        a_rdata_d  = a_rvalid_d ? ram_data_out : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? ram_data_out : b_rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_address_q  <= '0;
            ram_data_in_q  <= '0;
            ram_write_en_q <= 1'b0;
            tag1_q         <= TAG_IDLE;
            tag2_q         <= TAG_IDLE;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
        end else begin
            ram_address_q  <= ram_address_d;
            ram_data_in_q  <= ram_data_in_d;
            ram_write_en_q <= ram_write_en_d;
            tag1_q         <= tag1_d;
            tag2_q         <= tag2_d;
            a_rvalid_q     <= a_rvalid_d;
            b_rvalid_q     <= b_rvalid_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
        end
    end

    assign ram_address  = ram_address_q;
    assign ram_data_in  = ram_data_in_q;
    assign ram_write_en = ram_write_en_q;
    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed bench for ram_sp_arbiter with a behavioural 16 x 8 sync-read RAM.
module tb_ram_sp_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a_valid, a_ready, a_write, a_rvalid;
    logic [3:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_valid, b_ready, b_write, b_rvalid;
    logic [3:0] b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in, ram_data_out;
    logic       ram_write_en;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ram_sp_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_en(ram_write_en), .ram_data_out(ram_data_out)
    );

    // Single-port RAM, read-first, registered read data, never reset.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_a(input logic v, input logic w, input logic [3:0] ad, input logic [7:0] d);
        a_valid = v; a_write = w; a_addr = ad; a_wdata = d;
    endtask

    task automatic set_b(input logic v, input logic w, input logic [3:0] ad, input logic [7:0] d);
        b_valid = v; b_write = w; b_addr = ad; b_wdata = d;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        reset_n = 1'b0;
        cyc();
        chk("rst_addr",   ram_address, 0);
        chk("rst_din",    ram_data_in, 0);
        chk("rst_we",     ram_write_en, 0);
        chk("rst_arv",    a_rvalid, 0);
        chk("rst_brv",    b_rvalid, 0);
        chk("rst_ard",    a_rdata, 0);
        chk("rst_brd",    b_rdata, 0);
        reset_n = 1'b1;

        // A writes 3 = A5, then reads it back
        set_a(1, 1, 3, 8'hA5);
        #1 chk("t1_wr_ardy", a_ready, 1);
        chk("t1_wr_brdy", b_ready, 0);
        cyc();
        chk("t1_we",   ram_write_en, 1);
        chk("t1_addr", ram_address, 3);
        chk("t1_din",  ram_data_in, 8'hA5);
        set_a(1, 0, 3, 0);
        #1 chk("t1_rd_ardy", a_ready, 1);
        cyc();
        chk("t1_rd_we", ram_write_en, 0);
        set_a(0, 0, 0, 0);
        #1 chk("t1_idle_ardy", a_ready, 0);
        chk("t1_idle_brdy", b_ready, 0);
        cyc();
        chk("t1_arv_e2", a_rvalid, 0);
        chk("t1_addr_hold", ram_address, 3);
        cyc();
        chk("t1_arv_e3", a_rvalid, 1);
        chk("t1_ard",    a_rdata, 8'hA5);
        chk("t1_brv",    b_rvalid, 0);
        cyc();
        chk("t1_arv_end", a_rvalid, 0);
        chk("t1_ard_hold", a_rdata, 8'hA5);

        // Both valid every cycle after reset: A,B,A,B
        reset_dut();
        set_a(1, 1, 1, 8'h11);
        set_b(1, 1, 2, 8'h22);
        #1 chk("t2_c1_ardy", a_ready, 1);
        chk("t2_c1_brdy", b_ready, 0);
        cyc();
        chk("t2_c1_addr", ram_address, 1);
        set_a(1, 1, 15, 8'hFF);
        #1 chk("t2_c2_ardy", a_ready, 0);
        chk("t2_c2_brdy", b_ready, 1);
        cyc();
        chk("t2_c2_addr", ram_address, 2);
        chk("t2_c2_din",  ram_data_in, 8'h22);
        set_b(1, 1, 0, 8'h01);
        #1 chk("t2_c3_ardy", a_ready, 1);
        chk("t2_c3_brdy", b_ready, 0);
        cyc();
        chk("t2_c3_addr", ram_address, 15);
        #1 chk("t2_c4_ardy", a_ready, 0);
        chk("t2_c4_brdy", b_ready, 1);
        cyc();
        chk("t2_c4_addr", ram_address, 0);
        chk("t2_c4_din",  ram_data_in, 8'h01);
        chk("t2_c4_we",   ram_write_en, 1);
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        cyc();
        chk("t2_idle_we", ram_write_en, 0);
        cyc();
        cyc();

        // B writes 7 = 3C, A reads 7 on the next accepted cycle
        set_b(1, 1, 7, 8'h3C);
        #1 chk("t3_brdy", b_ready, 1);
        cyc();
        set_b(0, 0, 0, 0);
        set_a(1, 0, 7, 0);
        #1 chk("t3_ardy", a_ready, 1);
        cyc();
        set_a(0, 0, 0, 0);
        cyc();
        chk("t3_arv_early", a_rvalid, 0);
        cyc();
        chk("t3_arv", a_rvalid, 1);
        chk("t3_ard", a_rdata, 8'h3C);
        chk("t3_brv", b_rvalid, 0);
        cyc();

        // Back-to-back reads A1, B2, A1
        set_a(1, 0, 1, 0);
        #1 chk("t4_ardy", a_ready, 1);
        cyc();
        set_a(0, 0, 0, 0);
        set_b(1, 0, 2, 0);
        #1 chk("t4_brdy", b_ready, 1);
        cyc();
        set_b(0, 0, 0, 0);
        set_a(1, 0, 1, 0);
        cyc();
        chk("t4_r1_arv", a_rvalid, 1);
        chk("t4_r1_ard", a_rdata, 8'h11);
        chk("t4_r1_brv", b_rvalid, 0);
        set_a(0, 0, 0, 0);
        cyc();
        chk("t4_r2_brv", b_rvalid, 1);
        chk("t4_r2_brd", b_rdata, 8'h22);
        chk("t4_r2_arv", a_rvalid, 0);
        cyc();
        chk("t4_r3_arv", a_rvalid, 1);
        chk("t4_r3_ard", a_rdata, 8'h11);
        chk("t4_r3_brv", b_rvalid, 0);
        cyc();
        chk("t4_end_arv", a_rvalid, 0);
        chk("t4_end_brv", b_rvalid, 0);
        chk("t4_brd_hold", b_rdata, 8'h22);

        // Top and bottom addresses do not alias
        set_a(1, 0, 15, 0);
        cyc();
        set_a(1, 0, 0, 0);
        cyc();
        set_a(0, 0, 0, 0);
        cyc();
        chk("t5_r15_arv", a_rvalid, 1);
        chk("t5_r15_ard", a_rdata, 8'hFF);
        cyc();
        chk("t5_r0_arv", a_rvalid, 1);
        chk("t5_r0_ard", a_rdata, 8'h01);
        cyc();
        chk("t5_end_arv", a_rvalid, 0);

        // Reset one cycle after a read accept
        set_a(1, 0, 7, 0);
        cyc();
        set_a(0, 0, 0, 0);
        reset_n = 1'b0;
        #1 chk("t6_addr", ram_address, 0);
        chk("t6_din", ram_data_in, 0);
        chk("t6_we",  ram_write_en, 0);
        chk("t6_arv", a_rvalid, 0);
        chk("t6_ard", a_rdata, 0);
        chk("t6_brd", b_rdata, 0);
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_no_arv", a_rvalid, 0);
            chk("t6_no_brv", b_rvalid, 0);
        end
        set_a(1, 0, 7, 0);
        cyc();
        set_a(0, 0, 0, 0);
        cyc();
        cyc();
        chk("t6_persist_arv", a_rvalid, 1);
        chk("t6_persist_ard", a_rdata, 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
